// File: rtl/vx_afu_wr_gate.sv
// Per-bank AXI4 write handshake gate: throttles AW/W, tracks outstanding bursts, drains on request, flags B errors.
// Optional watchdog timeout enabled by defining VX_AFU_WR_GATE_TIMEOUT_EN.
module vx_afu_wr_gate #(
  parameter  int MAX_PENDING    = 64,
  parameter  int ID_WIDTH       = 8,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int CW             = $clog2(MAX_PENDING + 1)
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic                axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] axi_bid,
  input  logic [1:0]          axi_bresp,
  input  logic                drain_req,
  output logic                drain_done,
  output logic [CW-1:0]       pending_cnt,
  output logic [CW-1:0]       open_bursts,
  output logic                err_valid,
  output logic [ID_WIDTH-1:0] err_id,
  output logic [1:0]          err_code,
  input  logic                err_clear
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       pending_q, pending_d;
  logic [CW-1:0]       open_q, open_d;
  logic                err_valid_q, err_valid_d;
  logic [ID_WIDTH-1:0] err_id_q, err_id_d;
  logic [1:0]          err_code_q, err_code_d;

  logic aw_en, w_en;
  logic awfire, wfire, bfire;
  logic timeout_hit;

  // Gated handshakes are forced low while reset is asserted so no transfer can complete.
  assign aw_en = ap_rst_n && (state_q == RUN) && (pending_q != CW'(MAX_PENDING));
  assign w_en  = ap_rst_n && (open_q != '0);

  assign m_axi_awvalid = s_axi_awvalid & aw_en;
  assign s_axi_awready = m_axi_awready & aw_en;
  assign m_axi_wvalid  = s_axi_wvalid & w_en;
  assign s_axi_wready  = m_axi_wready & w_en;
  assign s_axi_bvalid  = m_axi_bvalid & ap_rst_n;
  assign m_axi_bready  = s_axi_bready & ap_rst_n;

  assign awfire = s_axi_awvalid & s_axi_awready;
  assign wfire  = s_axi_wvalid & s_axi_wready;
  assign bfire  = s_axi_bvalid & m_axi_bready;

  assign pending_cnt = pending_q;
  assign open_bursts = open_q;
  assign drain_done  = (state_q == DONE) && drain_req;
  assign err_valid   = err_valid_q;
  assign err_id      = err_id_q;
  assign err_code    = err_code_q;

`ifdef VX_AFU_WR_GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q, wd_d;

  // Watchdog saturates at the limit; the error fires only on the cycle it gets there.
  always_comb begin
    wd_d        = wd_q;
    timeout_hit = 1'b0;
    if (bfire || (pending_q == '0)) begin
      wd_d = '0;
    end else if (wd_q != TW'(TIMEOUT_CYCLES)) begin
      wd_d        = wd_q + TW'(1);
      timeout_hit = (wd_d == TW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) wd_q <= '0;
    else           wd_q <= wd_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    pending_d = pending_q;
    open_d    = open_q;
    if (awfire && !(bfire && (pending_q != '0))) pending_d = pending_q + CW'(1);
    else if (!awfire && bfire && (pending_q != '0)) pending_d = pending_q - CW'(1);
    if (awfire && !(wfire && axi_wlast)) open_d = open_q + CW'(1);
    else if (!awfire && wfire && axi_wlast) open_d = open_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req) state_d = RUN;
        else if ((pending_q == '0) && (open_q == '0)) state_d = DONE;
      end
      DONE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // First error wins; a clear coinciding with a new error lets the new one in.
  always_comb begin
    logic                new_err;
    logic [1:0]          new_code;
    logic [ID_WIDTH-1:0] new_id;
    new_err     = 1'b0;
    new_code    = 2'd0;
    new_id      = axi_bid;
    err_valid_d = err_valid_q;
    err_id_d    = err_id_q;
    err_code_d  = err_code_q;
    if (bfire && axi_bresp[1]) begin
      new_err  = 1'b1;
      new_code = {1'b0, axi_bresp[0]};
    end else if (bfire && (pending_q == '0)) begin
      new_err  = 1'b1;
      new_code = 2'd2;
    end else if (timeout_hit) begin
      new_err  = 1'b1;
      new_code = 2'd3;
      new_id   = '0;
    end
    if (err_clear) err_valid_d = 1'b0;
    if (new_err && (!err_valid_q || err_clear)) begin
      err_valid_d = 1'b1;
      err_id_d    = new_id;
      err_code_d  = new_code;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= RUN;
      pending_q   <= '0;
      open_q      <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      open_q      <= open_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_vx_afu_wr_gate.sv
// Directed self-checking bench for vx_afu_wr_gate (MAX_PENDING=4, TIMEOUT_CYCLES=16).
module tb_vx_afu_wr_gate;

  localparam int MP = 4;
  localparam int IW = 8;
  localparam int CW = $clog2(MP + 1);

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic          s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready, axi_wlast;
  logic          m_axi_bvalid, m_axi_bready, s_axi_bvalid, s_axi_bready;
  logic [IW-1:0] axi_bid;
  logic [1:0]    axi_bresp;
  logic          drain_req, drain_done;
  logic [CW-1:0] pending_cnt, open_bursts;
  logic          err_valid;
  logic [IW-1:0] err_id;
  logic [1:0]    err_code;
  logic          err_clear;

  int checks = 0;
  int errors = 0;

  vx_afu_wr_gate #(.MAX_PENDING(MP), .ID_WIDTH(IW), .TIMEOUT_CYCLES(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .axi_wlast(axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .drain_req(drain_req), .drain_done(drain_done),
    .pending_cnt(pending_cnt), .open_bursts(open_bursts),
    .err_valid(err_valid), .err_id(err_id), .err_code(err_code), .err_clear(err_clear)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic awv, input logic wv, input logic wl,
                               input logic bv, input logic [1:0] resp, input logic [IW-1:0] id);
    s_axi_awvalid = awv;
    s_axi_wvalid  = wv;
    axi_wlast     = wl;
    m_axi_bvalid  = bv;
    axi_bresp     = resp;
    axi_bid       = id;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ap_rst_n = 1'b0;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    s_axi_bready  = 1'b1;
    drain_req     = 1'b0;
    err_clear     = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h0);
    checkOutput("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    checkOutput("rst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("rst_wready", 32'(s_axi_wready), 32'd0);
    checkOutput("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("rst_pending", 32'(pending_cnt), 32'd0);
    checkOutput("rst_open", 32'(open_bursts), 32'd0);
    checkOutput("rst_drain_done", 32'(drain_done), 32'd0);
    checkOutput("rst_err", 32'({err_valid, err_id, err_code}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    #3 ap_rst_n = 1'b1;
    tick();

    // Single write, ID 5, four beats; W offered before AW
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h5);
    checkOutput("t1_awready", 32'(s_axi_awready), 32'd1);
    checkOutput("t1_w_before_aw", 32'(s_axi_wready), 32'd0);
    tick();
    checkOutput("t1_pending_1", 32'(pending_cnt), 32'd1);
    checkOutput("t1_open_1", 32'(open_bursts), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h5);
    checkOutput("t1_wready_after_aw", 32'(s_axi_wready), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("t1_open_mid", 32'(open_bursts), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h5);
    tick();
    checkOutput("t1_open_0", 32'(open_bursts), 32'd0);
    checkOutput("t1_wready_closed", 32'(s_axi_wready), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h5);
    checkOutput("t1_bvalid_pass", 32'(s_axi_bvalid), 32'd1);
    checkOutput("t1_bready_pass", 32'(m_axi_bready), 32'd1);
    tick();
    checkOutput("t1_pending_0", 32'(pending_cnt), 32'd0);
    checkOutput("t1_err_valid", 32'(err_valid), 32'd0);

    // Fill to MAX_PENDING, stall, then reopen after one B
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h1);
    for (int i = 0; i < MP; i++) tick();
    checkOutput("t2_pending_full", 32'(pending_cnt), 32'd4);
    checkOutput("t2_awready_full", 32'(s_axi_awready), 32'd0);
    checkOutput("t2_awvalid_full", 32'(m_axi_awvalid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h1);
    checkOutput("t2_awready_bfire", 32'(s_axi_awready), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h1);
    checkOutput("t2_pending_3", 32'(pending_cnt), 32'd3);
    checkOutput("t2_awready_reopen", 32'(s_axi_awready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h1);
    checkOutput("t2_pending_4", 32'(pending_cnt), 32'd4);
    checkOutput("t2_open_5", 32'(open_bursts), 32'd5);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h1);
    checkOutput("t2_open_drained", 32'(open_bursts), 32'd0);
    for (int i = 0; i < MP; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    checkOutput("t2_pending_drained", 32'(pending_cnt), 32'd0);
    checkOutput("t2_err_valid", 32'(err_valid), 32'd0);

    // Drain with two bursts outstanding
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h2);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h2);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h2);
    drain_req = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h2);
    checkOutput("t3_pending_2", 32'(pending_cnt), 32'd2);
    checkOutput("t3_aw_blocked", 32'(s_axi_awready), 32'd0);
    checkOutput("t3_done_early", 32'(drain_done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h2);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h2);
    checkOutput("t3_pending_0", 32'(pending_cnt), 32'd0);
    checkOutput("t3_done_not_yet", 32'(drain_done), 32'd0);
    tick();
    checkOutput("t3_drain_done", 32'(drain_done), 32'd1);
    checkOutput("t3_aw_blocked_done", 32'(s_axi_awready), 32'd0);
    drain_req = 1'b0;
    #1;
    checkOutput("t3_done_drop", 32'(drain_done), 32'd0);
    tick();
    checkOutput("t3_aw_reopen", 32'(s_axi_awready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);

    // Error capture: SLVERR first, DECERR ignored, clear, then underflow
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h3);
    tick();
    checkOutput("t4_err_valid", 32'(err_valid), 32'd1);
    checkOutput("t4_err_id_3", 32'(err_id), 32'h3);
    checkOutput("t4_err_code_0", 32'(err_code), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    checkOutput("t4_err_id_hold", 32'(err_id), 32'h3);
    checkOutput("t4_err_code_hold", 32'(err_code), 32'd0);
    checkOutput("t4_pending_0", 32'(pending_cnt), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("t4_err_cleared", 32'(err_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h9);
    checkOutput("t4_stray_pass", 32'(s_axi_bvalid), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    checkOutput("t4_under_valid", 32'(err_valid), 32'd1);
    checkOutput("t4_under_code", 32'(err_code), 32'd2);
    checkOutput("t4_under_id", 32'(err_id), 32'h9);
    checkOutput("t4_under_pending", 32'(pending_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h4);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h0);
    checkOutput("t4_clear_new_valid", 32'(err_valid), 32'd1);
    checkOutput("t4_clear_new_code", 32'(err_code), 32'd1);
    checkOutput("t4_clear_new_id", 32'(err_id), 32'h4);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    checkOutput("t4_open_closed", 32'(open_bursts), 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // One AW and no B; optionally let the watchdog expire
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    checkOutput("t5_pending_1", 32'(pending_cnt), 32'd1);
`ifdef VX_AFU_WR_GATE_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    checkOutput("t5_no_early_timeout", 32'(err_valid), 32'd0);
    for (int i = 0; i < 40 && !err_valid; i++) tick();
    checkOutput("t5_timeout_valid", 32'(err_valid), 32'd1);
    checkOutput("t5_timeout_code", 32'(err_code), 32'd3);
    checkOutput("t5_timeout_id", 32'(err_id), 32'h0);
`else
    for (int i = 0; i < 20; i++) tick();
    checkOutput("t5_no_timeout", 32'(err_valid), 32'd0);
`endif

    // Async reset mid-burst with all requests asserted
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h0);
    #2 ap_rst_n = 1'b0;
    #1;
    checkOutput("t6_outputs_zero",
                32'({m_axi_awvalid, s_axi_awready, m_axi_wvalid, s_axi_wready,
                     s_axi_bvalid, m_axi_bready, drain_done, err_valid}), 32'd0);
    checkOutput("t6_counts_zero", 32'({pending_cnt, open_bursts}), 32'd0);
    tick();
    checkOutput("t6_held_zero", 32'({s_axi_awready, pending_cnt}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0);
    ap_rst_n = 1'b1;
    tick();
    checkOutput("t6_post_reset_pending", 32'(pending_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
